// File: rtl/cardjitsu_match.sv
// Two-player card duel: both hands are loaded from the switches, players pick cards in turn,
// and each round is scored by element and power until one player wins the match or both hands run out.
module cardjitsu_match #(
    parameter int HAND_SIZE    = 6,
    parameter int WIN_TARGET   = 3,
    parameter int LIFE_INIT    = 8,
    parameter int ELEMENT_MODE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_0,
    input  logic       btn_1,
    input  logic       btn_2,
    input  logic [3:0] sw,
    output logic [3:0] leds,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [1:0] winner,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_P1_PICK = 3'd1,
        ST_P2_PICK = 3'd2,
        ST_EVAL    = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Element a beats element b: fire>snow, snow>water, water>fire.
    function automatic logic elem_beats(input logic [1:0] a, input logic [1:0] b);
        return ((a == 2'b01) && (b == 2'b11)) ||
               ((a == 2'b11) && (b == 2'b10)) ||
               ((a == 2'b10) && (b == 2'b01));
    endfunction

    // Round outcome: 2'b01 P1 wins, 2'b10 P2 wins, 2'b00 tie.
    function automatic logic [1:0] round_result(input logic [3:0] c1, input logic [3:0] c2);
        logic [1:0] res;
        if ((ELEMENT_MODE == 1) && (c1[3:2] != 2'b00) && (c2[3:2] != 2'b00) &&
            (c1[3:2] != c2[3:2])) begin
            res = elem_beats(c1[3:2], c2[3:2]) ? 2'b01 : 2'b10;
        end else if (c1[1:0] > c2[1:0]) begin
            res = 2'b01;
        end else if (c2[1:0] > c1[1:0]) begin
            res = 2'b10;
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

    // Loser loses winner power + 1, floored at zero.
    function automatic logic [3:0] apply_damage(input logic [3:0] life, input logic [3:0] card);
        logic [3:0] dmg;
        dmg = {2'b00, card[1:0]} + 4'd1;
        return (life > dmg) ? (life - dmg) : 4'd0;
    endfunction

    state_t     state_q, state_d;
    logic [1:0] sync_q;
    logic       btn_prev_q;
    logic       press_s;

    logic [3:0] p1_hand_q [HAND_SIZE];
    logic [3:0] p1_hand_d [HAND_SIZE];
    logic [3:0] p2_hand_q [HAND_SIZE];
    logic [3:0] p2_hand_d [HAND_SIZE];
    logic [3:0] p1_cnt_q, p1_cnt_d, p2_cnt_q, p2_cnt_d;
    logic [3:0] p1_wins_q, p1_wins_d, p2_wins_q, p2_wins_d;
    logic [3:0] p1_life_q, p1_life_d, p2_life_q, p2_life_d;
    logic [3:0] p1_card_q, p1_card_d, p2_card_q, p2_card_d;
    logic [1:0] winner_q, winner_d;

    logic [3:0] p1_sel_s, p2_sel_s;
    logic       hands_empty_s;
    logic [1:0] round_s;

    assign press_s = sync_q[1] & ~btn_prev_q;
    assign round_s = round_result(p1_card_q, p2_card_q);

    // Button synchronizer and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b00;
            btn_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn_0};
            btn_prev_q <= sync_q[1];
        end
    end

    // Card under the slot number on sw, and whether every slot is already played.
    always_comb begin
        p1_sel_s      = 4'h0;
        p2_sel_s      = 4'h0;
        hands_empty_s = 1'b1;
        for (int i = 0; i < HAND_SIZE; i++) begin
            if (sw == 4'(i + 1)) begin
                p1_sel_s = p1_hand_q[i];
                p2_sel_s = p2_hand_q[i];
            end else begin
                p1_sel_s = p1_sel_s;
                p2_sel_s = p2_sel_s;
            end
            if ((p1_hand_q[i] != 4'h0) || (p2_hand_q[i] != 4'h0)) begin
                hands_empty_s = 1'b0;
            end else begin
                hands_empty_s = hands_empty_s;
            end
        end
    end

    // Game state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            p1_cnt_q  <= 4'd0;
            p2_cnt_q  <= 4'd0;
            p1_wins_q <= 4'd0;
            p2_wins_q <= 4'd0;
            p1_life_q <= 4'(LIFE_INIT);
            p2_life_q <= 4'(LIFE_INIT);
            p1_card_q <= 4'h0;
            p2_card_q <= 4'h0;
            winner_q  <= 2'b00;
            for (int i = 0; i < HAND_SIZE; i++) begin
                p1_hand_q[i] <= 4'h0;
                p2_hand_q[i] <= 4'h0;
            end
        end else begin
            state_q   <= state_d;
            p1_cnt_q  <= p1_cnt_d;
            p2_cnt_q  <= p2_cnt_d;
            p1_wins_q <= p1_wins_d;
            p2_wins_q <= p2_wins_d;
            p1_life_q <= p1_life_d;
            p2_life_q <= p2_life_d;
            p1_card_q <= p1_card_d;
            p2_card_q <= p2_card_d;
            winner_q  <= winner_d;
            for (int i = 0; i < HAND_SIZE; i++) begin
                p1_hand_q[i] <= p1_hand_d[i];
                p2_hand_q[i] <= p2_hand_d[i];
            end
        end
    end

    // Next-state logic for the match flow.
    always_comb begin
        state_d   = state_q;
        p1_hand_d = p1_hand_q;
        p2_hand_d = p2_hand_q;
        p1_cnt_d  = p1_cnt_q;
        p2_cnt_d  = p2_cnt_q;
        p1_wins_d = p1_wins_q;
        p2_wins_d = p2_wins_q;
        p1_life_d = p1_life_q;
        p2_life_d = p2_life_q;
        p1_card_d = p1_card_q;
        p2_card_d = p2_card_q;
        winner_d  = winner_q;

        case (state_q)
            ST_LOAD: begin
                if (p2_cnt_q == 4'(HAND_SIZE)) begin
                    state_d  = ST_P1_PICK;
                    p1_cnt_d = 4'd0;
                    p2_cnt_d = 4'd0;
                end else if (press_s && (sw != 4'h0)) begin
                    if (p1_cnt_q < 4'(HAND_SIZE)) begin
                        for (int i = 0; i < HAND_SIZE; i++) begin
                            if (p1_cnt_q == 4'(i)) p1_hand_d[i] = sw;
                            else                   p1_hand_d[i] = p1_hand_q[i];
                        end
                        p1_cnt_d = p1_cnt_q + 4'd1;
                    end else begin
                        for (int i = 0; i < HAND_SIZE; i++) begin
                            if (p2_cnt_q == 4'(i)) p2_hand_d[i] = sw;
                            else                   p2_hand_d[i] = p2_hand_q[i];
                        end
                        p2_cnt_d = p2_cnt_q + 4'd1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_P1_PICK: begin
                if (press_s && (p1_sel_s != 4'h0)) begin
                    p1_card_d = p1_sel_s;
                    for (int i = 0; i < HAND_SIZE; i++) begin
                        if (sw == 4'(i + 1)) p1_hand_d[i] = 4'h0;
                        else                 p1_hand_d[i] = p1_hand_q[i];
                    end
                    state_d = ST_P2_PICK;
                end else begin
                    state_d = ST_P1_PICK;
                end
            end
            ST_P2_PICK: begin
                if (press_s && (p2_sel_s != 4'h0)) begin
                    p2_card_d = p2_sel_s;
                    for (int i = 0; i < HAND_SIZE; i++) begin
                        if (sw == 4'(i + 1)) p2_hand_d[i] = 4'h0;
                        else                 p2_hand_d[i] = p2_hand_q[i];
                    end
                    state_d = ST_EVAL;
                end else begin
                    state_d = ST_P2_PICK;
                end
            end
            ST_EVAL: begin
                case (round_s)
                    2'b01: begin
                        p1_wins_d = p1_wins_q + 4'd1;
                        p2_life_d = apply_damage(p2_life_q, p1_card_q);
                    end
                    2'b10: begin
                        p2_wins_d = p2_wins_q + 4'd1;
                        p1_life_d = apply_damage(p1_life_q, p2_card_q);
                    end
                    default: begin
                        p1_wins_d = p1_wins_q;
                    end
                endcase
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if ((p2_life_q == 4'd0) || (p1_wins_q == 4'(WIN_TARGET))) begin
                    winner_d = 2'b01;
                    state_d  = ST_DONE;
                end else if ((p1_life_q == 4'd0) || (p2_wins_q == 4'(WIN_TARGET))) begin
                    winner_d = 2'b10;
                    state_d  = ST_DONE;
                end else if (hands_empty_s) begin
                    winner_d = 2'b11;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_P1_PICK;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Display decode; btn_0 only reaches it through registered state.
    always_comb begin
        leds   = 4'b0000;
        led_r  = 1'b0;
        led_g  = 1'b0;
        led_b  = 1'b0;
        winner = winner_q;
        done   = 1'b0;

        case (state_q)
            ST_LOAD:    led_g = 1'b1;
            ST_P1_PICK: led_b = 1'b1;
            ST_P2_PICK: led_r = 1'b1;
            ST_DONE: begin
                done  = 1'b1;
                led_b = winner_q[0];
                led_r = winner_q[1];
                led_g = (winner_q == 2'b11);
            end
            default: led_g = 1'b0;
        endcase

        if (btn_1) begin
            leds = (sw == 4'hF) ? p1_life_q : p1_wins_q;
        end else if (btn_2) begin
            leds = (sw == 4'hF) ? p2_life_q : p2_wins_q;
        end else begin
            case (state_q)
                ST_LOAD: leds = p1_cnt_q + p2_cnt_q;
                ST_EVAL: begin
                    case (round_s)
                        2'b01:   leds = 4'b1000;
                        2'b10:   leds = 4'b0001;
                        default: leds = 4'b0000;
                    endcase
                end
                ST_DONE: begin
                    case (winner_q)
                        2'b01:   leds = 4'b1100;
                        2'b10:   leds = 4'b0011;
                        2'b11:   leds = 4'b1111;
                        default: leds = 4'b0000;
                    endcase
                end
                default: leds = 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_cardjitsu_match.sv
// Directed bench for cardjitsu_match: a game-rules model predicts every output each cycle,
// and hand-computed literals pin the key scenarios.
module tb_cardjitsu_match;
    localparam int HS = 6;
    localparam int WT = 3;
    localparam int LI = 8;
    localparam int EM = 1;

    localparam int M_LOAD = 0, M_P1 = 1, M_P2 = 2, M_EVAL = 3, M_CHECK = 4, M_DONE = 5;

    logic       clk = 1'b0;
    logic       rst, btn_0, btn_1, btn_2;
    logic [3:0] sw;
    logic [3:0] leds;
    logic       led_r, led_g, led_b;
    logic [1:0] winner;
    logic       done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int m_phase, cnt1, cnt2, w1, w2, l1, l2, c1, c2, m_win;
    int p1h [HS];
    int p2h [HS];
    int s;

    always #5 clk = ~clk;

    cardjitsu_match #(.HAND_SIZE(HS), .WIN_TARGET(WT), .LIFE_INIT(LI), .ELEMENT_MODE(EM)) dut (
        .clk(clk), .rst(rst), .btn_0(btn_0), .btn_1(btn_1), .btn_2(btn_2), .sw(sw),
        .leds(leds), .led_r(led_r), .led_g(led_g), .led_b(led_b), .winner(winner), .done(done)
    );

    function automatic int rnd(input int a, input int b);
        int ea = a / 4, eb = b / 4, pa = a % 4, pb = b % 4;
        if (EM == 1 && ea != 0 && eb != 0 && ea != eb) begin
            if ((ea == 1 && eb == 3) || (ea == 3 && eb == 2) || (ea == 2 && eb == 1)) return 1;
            return 2;
        end
        if (pa > pb) return 1;
        if (pb > pa) return 2;
        return 0;
    endfunction

    function automatic void m_reset();
        m_phase = M_LOAD; cnt1 = 0; cnt2 = 0; w1 = 0; w2 = 0;
        l1 = LI; l2 = LI; c1 = 0; c2 = 0; m_win = 0;
        for (int i = 0; i < HS; i++) begin p1h[i] = 0; p2h[i] = 0; end
    endfunction

    function automatic void m_press(input int code);
        if (m_phase == M_LOAD && code != 0) begin
            if (cnt1 < HS) begin p1h[cnt1] = code; cnt1++; end
            else if (cnt2 < HS) begin p2h[cnt2] = code; cnt2++; end
        end else if (m_phase == M_P1 && code >= 1 && code <= HS) begin
            if (p1h[code-1] != 0) begin c1 = p1h[code-1]; p1h[code-1] = 0; m_phase = M_P2; end
        end else if (m_phase == M_P2 && code >= 1 && code <= HS) begin
            if (p2h[code-1] != 0) begin c2 = p2h[code-1]; p2h[code-1] = 0; m_phase = M_EVAL; end
        end
    endfunction

    function automatic void m_score();
        int r = rnd(c1, c2);
        if (r == 1) begin w1++; l2 = (l2 > c1 % 4 + 1) ? l2 - (c1 % 4 + 1) : 0; end
        if (r == 2) begin w2++; l1 = (l1 > c2 % 4 + 1) ? l1 - (c2 % 4 + 1) : 0; end
    endfunction

    function automatic void m_check();
        int left = 0;
        for (int i = 0; i < HS; i++) left += p1h[i] + p2h[i];
        if (l2 == 0 || w1 == WT)      begin m_phase = M_DONE; m_win = 1; end
        else if (l1 == 0 || w2 == WT) begin m_phase = M_DONE; m_win = 2; end
        else if (left == 0)           begin m_phase = M_DONE; m_win = 3; end
        else m_phase = M_P1;
    endfunction

    function automatic int exp_leds();
        int r;
        if (btn_1) return (sw == 4'hF) ? l1 : w1;
        if (btn_2) return (sw == 4'hF) ? l2 : w2;
        case (m_phase)
            M_LOAD: return (cnt1 + cnt2) % 16;
            M_EVAL: begin r = rnd(c1, c2); return (r == 1) ? 8 : (r == 2) ? 1 : 0; end
            M_DONE: return (m_win == 1) ? 12 : (m_win == 2) ? 3 : 15;
            default: return 0;
        endcase
    endfunction

    // {r,g,b}
    function automatic int exp_rgb();
        case (m_phase)
            M_LOAD: return 2;
            M_P1:   return 1;
            M_P2:   return 4;
            M_DONE: return (m_win == 1) ? 1 : (m_win == 2) ? 4 : 7;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the rules model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("leds", int'(leds), exp_leds());
            check("rgb", int'({led_r, led_g, led_b}), exp_rgb());
            check("winner", int'(winner), (m_phase == M_DONE) ? m_win : 0);
            check("done", int'(done), (m_phase == M_DONE) ? 1 : 0);
        end
    end

    task automatic press(input int code, input int hold, output int snap);
        @(posedge clk); #1;
        sw = 4'(code); btn_0 = 1'b1; chk_en = 1'b0;
        repeat (3) @(posedge clk);
        m_press(code);
        chk_en = 1'b1;
        #2 snap = int'(leds);
        if (m_phase == M_LOAD && cnt2 == HS) begin
            @(posedge clk); m_phase = M_P1; cnt1 = 0; cnt2 = 0;
        end else if (m_phase == M_EVAL) begin
            @(posedge clk); m_score(); m_phase = M_CHECK;
            @(posedge clk); m_check();
        end
        repeat (hold) @(posedge clk);
        #1 btn_0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic show(input int which, input int swv, output int snap);
        @(posedge clk); #1;
        sw = 4'(swv);
        if (which == 1) btn_1 = 1'b1; else btn_2 = 1'b1;
        @(negedge clk); #1 snap = int'(leds);
        @(posedge clk); #1;
        btn_1 = 1'b0; btn_2 = 1'b0;
    endtask

    task automatic load_all(input int a [12]);
        for (int i = 0; i < 12; i++) press(a[i], 0, s);
    endtask

    initial begin
        int seq_a [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        int seq_b [12] = '{5, 1, 1, 1, 1, 1, 13, 1, 1, 1, 1, 1};
        rst = 1'b1; btn_0 = 1'b0; btn_1 = 1'b0; btn_2 = 1'b0; sw = 4'h0;
        m_reset();
        #12;
        check("rst_leds", int'(leds), 0);
        check("rst_rgb", int'({led_r, led_g, led_b}), 2);
        check("rst_winner", int'(winner), 0);
        check("rst_done", int'(done), 0);
        @(posedge clk); #1 rst = 1'b0; chk_en = 1'b1;

        // Held button loads exactly one card.
        press(1, 97, s);
        check("hold_first", s, 1);
        check("hold_once", int'(leds), 1);
        press(0, 0, s);
        check("zero_ignored", s, 1);
        for (int i = 2; i <= 12; i++) begin
            press(i, 0, s);
            check("load_count", s, i);
        end
        check("p1pick_blue", int'(led_b), 1);

        // R1: fire1 vs snow0 -> P1
        press(5, 0, s); press(6, 0, s);
        check("r1_eval", s, 8);
        show(2, 15, s); check("r1_p2life", s, 6);
        show(1, 0, s);  check("r1_p1wins", s, 1);
        // Used slot and out-of-range slot are ignored.
        press(5, 0, s); press(7, 0, s);
        check("bad_pick_stay", int'({led_r, led_g, led_b}), 1);
        // R2: neutral3 vs water1 -> P1
        press(3, 0, s); press(3, 0, s);
        check("r2_eval", s, 8);
        show(2, 15, s); check("r2_p2life", s, 2);
        // R3: neutral2 vs water2 -> tie
        press(2, 0, s); press(4, 0, s);
        check("r3_tie", s, 0);
        // R4: fire2 vs fire3 -> P2
        press(6, 0, s); press(1, 0, s);
        check("r4_eval", s, 1);
        show(1, 15, s); check("r4_p1life", s, 4);
        // R5: neutral1 vs water0 -> P1, third win
        press(1, 0, s); press(2, 0, s);
        check("r5_eval", s, 8);
        check("p1_winner", int'(winner), 1);
        check("p1_done_leds", int'(leds), 12);
        check("p1_done", int'(done), 1);
        show(2, 15, s); check("p2life_sat", s, 0);
        press(1, 0, s);
        check("done_hold", int'(done), 1);

        // Reset out of DONE, then again mid P2_PICK.
        @(posedge clk); #1 rst = 1'b1; m_reset();
        #2 check("rst2_leds", int'(leds), 0);
        @(posedge clk); #1 rst = 1'b0;
        load_all(seq_a);
        press(1, 0, s);
        check("in_p2pick", int'(led_r), 1);
        @(posedge clk); #3 rst = 1'b1; m_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        check("midrst_leds", int'(leds), 0);
        check("midrst_g", int'(led_g), 1);
        show(1, 15, s); check("midrst_life", s, 8);

        // Fire vs snow, then all ties to a draw.
        load_all(seq_b);
        press(1, 0, s); press(1, 0, s);
        check("fire_snow", s, 8);
        show(2, 15, s); check("fs_p2life", s, 6);
        show(1, 0, s);  check("fs_p1wins", s, 1);
        for (int i = 2; i <= HS; i++) begin
            press(i, 0, s); press(i, 0, s);
            check("tie_round", s, 0);
        end
        check("draw_winner", int'(winner), 3);
        check("draw_leds", int'(leds), 15);
        check("draw_rgb", int'({led_r, led_g, led_b}), 7);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
